// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode encodings,
// per-stage side information and the chunk-width helper.
package adder_pkg;

  localparam logic ADD_MODE = 1'b0;
  localparam logic SUB_MODE = 1'b1;

  // Side information that travels with each operation; the wide fields
  // (operand remainders, partial sum) are width-parameterised in the top.
  typedef struct packed {
    logic sub;
    logic a_msb;
    logic b_msb;
  } stage_meta_t;

  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? width / stages : 1;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One registered CHUNK-bit carry-chain slice with a valid bit and a shared
// pipeline enable.
module adder_pipe_stage #(
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_prev,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic             valid,
  output logic [CHUNK-1:0] sum,
  output logic             co
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
    end else if (en) begin
      valid     <= valid_prev;
      {co, sum} <= {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: STAGES carry-chain slices of WIDTH/STAGES bits,
// a single global stall enable and registered outputs.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be >= 1, STAGES >= 1 and WIDTH %% STAGES == 0");
  end

  // Handshake: a stage register moves only when en is high; en is high
  // whenever the output slot is empty or being drained this cycle, so input
  // and output transfers can coincide at full throughput.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtraction is a + ~b + ~borrow_in; the inversion happens before stage 0.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  stage_meta_t      meta_in;
  assign b_eff   = (sub == SUB_MODE) ? ~din2 : din2;
  assign c_eff   = (sub == SUB_MODE) ? ~cin : cin;
  assign meta_in = '{sub: sub, a_msb: din1[WIDTH-1], b_msb: b_eff[WIDTH-1]};

  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] lo_q   [STAGES];
  logic [WIDTH-1:0] view   [STAGES];
  logic [CHUNK-1:0] sum_q  [STAGES];
  logic             co_q   [STAGES];
  logic             vld_q  [STAGES];
  stage_meta_t      meta_q [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, lo_in;
    logic             c_in, v_in;
    stage_meta_t      m_in;

    if (k == 0) begin : g_first
      assign a_in  = din1;
      assign b_in  = b_eff;
      assign lo_in = '0;
      assign c_in  = c_eff;
      assign v_in  = in_valid;
      assign m_in  = meta_in;
    end else begin : g_next
      assign a_in  = a_q[k-1];
      assign b_in  = b_q[k-1];
      assign lo_in = view[k-1];
      assign c_in  = co_q[k-1];
      assign v_in  = vld_q[k-1];
      assign m_in  = meta_q[k-1];
    end

    adder_pipe_stage #(.CHUNK(CHUNK)) u_slice (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .valid_prev (v_in),
      .a          (a_in[k*CHUNK +: CHUNK]),
      .b          (b_in[k*CHUNK +: CHUNK]),
      .ci         (c_in),
      .valid      (vld_q[k]),
      .sum        (sum_q[k]),
      .co         (co_q[k])
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        lo_q[k]   <= '0;
        meta_q[k] <= '0;
      end else if (en) begin
        a_q[k]    <= a_in;
        b_q[k]    <= b_in;
        lo_q[k]   <= lo_in;
        meta_q[k] <= m_in;
      end
    end

    // lo_q holds only slices below k, so OR-ing in this slice is exact.
    assign view[k] = lo_q[k] | (WIDTH'(sum_q[k]) << (k * CHUNK));
  end

  assign out_valid = vld_q[LAST];
  assign dout      = view[LAST];
  assign cout      = co_q[LAST] ^ meta_q[LAST].sub;
  assign ovf       = (meta_q[LAST].a_msb == meta_q[LAST].b_msb) &&
                     (view[LAST][WIDTH-1] != meta_q[LAST].a_msb);

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: 32-bit/4-stage instance with a scoreboard,
// plus an 8-bit single-stage instance.
module tb_adder_pipe;

  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] din1, din2, dout;

  logic       e_in_valid, e_in_ready, e_cin, e_sub, e_out_valid, e_cout, e_ovf;
  logic [7:0] e_din1, e_din2, e_dout;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din1(din1), .din2(din2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .cout(cout), .ovf(ovf)
  );

  adder_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .din1(e_din1), .din2(e_din2), .cin(e_cin), .sub(e_sub),
    .out_valid(e_out_valid), .out_ready(1'b1),
    .dout(e_dout), .cout(e_cout), .ovf(e_ovf)
  );

  logic [W+1:0] exp_q[$];
  int n_cmp   = 0;
  int n_bad   = 0;
  int pop_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, packed as {ovf, cout, dout}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    logic [W:0]   ua, ub, t;
    logic [W-1:0] d;
    logic         co, ov;
    longint       sa, sb, r, lim;
    ua  = {1'b0, a};
    ub  = {1'b0, b};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) <<< (W - 1);
    if (s) begin
      t  = ua - ub - {{W{1'b0}}, c};
      co = (ua < (ub + {{W{1'b0}}, c}));
      r  = sa - sb - longint'(c);
    end else begin
      t  = ua + ub + {{W{1'b0}}, c};
      co = t[W];
      r  = sa + sb + longint'(c);
    end
    d  = t[W-1:0];
    ov = (r >= lim) || (r < -lim);
    return {ov, co, d};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_output: observed %0h expected no result", dout);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("result", {30'b0, ovf, cout, dout}, {30'b0, e});
        pop_cnt++;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    int n = 0;
    @(negedge clk);
    din1 = a; din2 = b; cin = c; sub = s; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1 within 100 cycles");
    end else begin
      exp_q.push_back(model(a, b, c, s));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic latency_after_send(input string tag);
    int lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check(tag, 64'(lat), 64'(S));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din1 = '0; din2 = '0; cin = 1'b0; sub = 1'b0;
    e_in_valid = 1'b0; e_din1 = '0; e_din2 = '0; e_cin = 1'b0; e_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", {30'b0, ovf, cout, dout}, 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Carry ripples through every slice.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    latency_after_send("latency_add");
    check("add_wrap", {30'b0, ovf, cout, dout}, {30'b0, 1'b0, 1'b1, 32'h0000_0000});
    drain("drain_add");

    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
    send(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1);
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    drain("drain_directed");
    check("sub_borrow_const", model(32'h5, 32'h7, 1'b0, 1'b1), {1'b0, 1'b1, 32'hFFFF_FFFE});
    check("add_ovf_const", model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0), {1'b1, 1'b0, 32'h8000_0000});

    // Ten back-to-back adds with a 5-cycle consumer stall after the 2nd result.
    base = pop_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) send(32'(i), 32'h100, 1'b0, 1'b0);
      end
      begin
        int n = 0;
        while (pop_cnt < base + 2 && n < 200) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          if (exp_q.size() != 0)
            check("stall_frozen", {30'b0, ovf, cout, dout}, {30'b0, exp_q[0]});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stream");
    check("stream_count", 64'(pop_cnt - base), 64'd10);

    // Reset with three operations in flight; none of them may surface.
    for (int i = 0; i < 3; i++) send(32'hA0 + 32'(i), 32'h5, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_outputs", {30'b0, ovf, cout, dout}, 64'd0);
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    send(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0);
    latency_after_send("latency_after_reset");
    drain("drain_after_reset");

    for (int i = 0; i < 8; i++)
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain("drain_random");

    // 8-bit single-stage instance: one-cycle latency.
    @(negedge clk);
    e_din1 = 8'h80; e_din2 = 8'h80; e_cin = 1'b0; e_sub = 1'b0; e_in_valid = 1'b1;
    check("w8_in_ready", 64'(e_in_ready), 64'd1);
    @(posedge clk);
    #1 e_din1 = 8'h10; e_din2 = 8'h20; e_sub = 1'b1;
    check("w8_out_valid", 64'(e_out_valid), 64'd1);
    check("w8_add", {54'b0, e_ovf, e_cout, e_dout}, {54'b0, 1'b1, 1'b1, 8'h00});
    @(posedge clk);
    #1 e_in_valid = 1'b0;
    check("w8_sub", {54'b0, e_ovf, e_cout, e_dout}, {54'b0, 1'b0, 1'b1, 8'hF0});
    @(posedge clk);
    #1;
    check("w8_idle", 64'(e_out_valid), 64'd0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised pipelined add/subtract unit. Successor to the fixed 8-bit registered-output adder.
- Operand width and pipeline depth are configurable.
- Adds a subtract mode, a signed-overflow flag, a synchronous reset, and a valid/ready handshake with back-pressure.
- Sits between the operand register stage and the result consumer; sustains one operation per cycle when not stalled.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 1.
STAGES, 4, number of pipeline stages (latency in cycles); must be >= 1, and WIDTH % STAGES must be 0. Violation is an elaboration-time error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands this cycle
din1  input  WIDTH  operand A
din2  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
dout  output  WIDTH  result
cout  output  1  carry-out (add) / borrow-out (sub)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset is synchronous and active-high: the block samples rst only on the rising edge of clk.
- Reset values (on the clk edge with rst=1): all stage valid bits = 0, out_valid = 0, dout = 0, cout = 0, ovf = 0; internal data registers cleared to 0.
- Reset mid-operation: all in-flight operations are discarded, and no result for them is ever presented. rst has priority over every other input.
- Arithmetic, with CHUNK = WIDTH/STAGES:
  - Add: {cout,dout} = din1 + din2 + cin.
  - Sub: dout = din1 - din2 - cin, computed as din1 + ~din2 + ~cin; cout = NOT(final carry), i.e. 1 when a borrow occurs.
  - ovf = (A_msb == B'_msb) && (dout_msb != A_msb), where B' = din2 for add and ~din2 for sub.
- Pipeline:
  - Stage k (0..STAGES-1) adds bit slice [k*CHUNK +: CHUNK] using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
  - Upper operand slices are delayed alongside; already-computed lower result slices are carried forward.
  - The last stage register drives dout, cout, ovf and out_valid directly (registered outputs, no combinational path from inputs to outputs).
- Handshake:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
  - When en = 1, every stage register loads from its predecessor, and stage 0 loads the inputs with valid = in_valid.
  - When en = 0, all stage registers hold, and dout/cout/ovf/out_valid are stable.
  - Bubbles are not compressed; results emerge in strict acceptance order.
- Latency: exactly STAGES cycles from the accepting edge to out_valid=1 when not stalled. Throughput is 1 operation/cycle.
- Data fields of invalid stages are don't-care; with out_valid=0, dout may change.
- Simultaneous out accept and in accept in the same cycle is allowed (full throughput).
- sub and cin are sampled with the operands and travel with them.

Decomposition:
- Package adder_pkg holds:
  - localparam function chunk_w(WIDTH, STAGES);
  - the mode encodings ADD_MODE=1'b0 and SUB_MODE=1'b1;
  - a packed struct/typedef for the per-stage payload (operand remainders, partial sum, carry, sub, msb info).
- Sub-module adder_pipe_stage (param CHUNK) contains one registered CHUNK-bit carry-chain slice with valid and enable; the top level instantiates STAGES copies in a generate loop plus the output/overflow logic.

Test Plan:
1. WIDTH=32, STAGES=4: add 0xFFFFFFFF + 0x00000001, cin=0, out_ready=1 -> 4 cycles later out_valid=1, dout=0x00000000, cout=1, ovf=0.
2. Sub 0x00000005 - 0x00000007, cin=0 -> dout=0xFFFFFFFE, cout=1 (borrow), ovf=0. Then sub 0x80000000 - 0x00000001 -> dout=0x7FFFFFFF, cout=0, ovf=1.
3. Add 0x7FFFFFFF + 0x00000001, cin=0 -> dout=0x80000000, cout=0, ovf=1. Add 0x00000010 + 0x00000020, cin=1 -> 0x00000031.
4. Stream 10 back-to-back adds (i + 0x100, i=0..9); hold out_ready=0 for 5 cycles after the 2nd result -> in_ready=0 and outputs frozen during the stall; all 10 results delivered in order, none lost or duplicated.
5. Accept 3 ops, assert rst for 1 cycle on cycle 2 -> next edge out_valid=0, dout=0, cout=0, ovf=0; no stale results appear; a new op after reset returns the correct result at latency 4.
6. WIDTH=8, STAGES=1: add 0x80 + 0x80, cin=0 -> 1 cycle later dout=0x00, cout=1, ovf=1. WIDTH=12, STAGES=5 -> elaboration error.
